// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Exception codes match the pipeline-wide 4-bit encoding.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    DRAIN,
    PRESENT,
    EXC
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_REDIRECT,
    PC_TRAP
  } pc_sel_t;

  localparam logic [3:0]  EXC_NONE               = 4'hF;
  localparam logic [3:0]  EXC_INSTR_MISALIGNED   = 4'h0;
  localparam logic [3:0]  EXC_INSTR_ACCESS_FAULT = 4'h1;
  localparam logic [31:0] RESET_PC_DEFAULT       = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with next-PC select: trap vector, branch target, +4 or hold.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  pc_sel_t     sel,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] trap_vector,
  output logic [31:0] pc
);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;

  always_comb begin
    pc_next = pc_reg;
    case (sel)
      PC_INC:      pc_next = pc_reg + 32'd4;
      PC_REDIRECT: pc_next = redirect_pc;
      PC_TRAP:     pc_next = trap_vector;
      default:     pc_next = pc_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC;
    end else if (en) begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a
// time and holds the fetched word (or fetch exception) until decode consumes it.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clk_en,
  input  logic        i_stall_f,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_trap,
  input  logic [31:0] i_trap_vector,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_err,
  output logic        o_valid_f,
  output logic [31:0] o_instr_f,
  output logic [31:0] o_pc_f,
  output logic [31:0] o_pc_p4_f,
  output logic [3:0]  o_exception_code_f
);

  fetch_state_t state_reg, state_next;
  pc_sel_t      pc_sel;
  logic [31:0]  pc;
  logic         req;
  logic         redirect_any;

  logic         valid_reg, valid_next;
  logic [31:0]  instr_reg, instr_next;
  logic [31:0]  pc_out_reg, pc_out_next;
  logic [3:0]   exc_reg, exc_next;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .en          (i_clk_en),
    .sel         (pc_sel),
    .redirect_pc (i_redirect_pc),
    .trap_vector (i_trap_vector),
    .pc          (pc)
  );

  assign redirect_any = i_trap | i_redirect;

  always_comb begin
    state_next  = state_reg;
    pc_sel      = PC_HOLD;
    req         = 1'b0;
    valid_next  = valid_reg;
    instr_next  = instr_reg;
    pc_out_next = pc_out_reg;
    exc_next    = exc_reg;

    // A redirect always wins the PC, whatever the state does with it.
    if (redirect_any) begin
      pc_sel = i_trap ? PC_TRAP : PC_REDIRECT;
    end

    case (state_reg)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (!redirect_any) begin
          if (pc[1:0] != 2'b00) begin
            valid_next  = 1'b1;
            instr_next  = 32'd0;
            pc_out_next = pc;
            exc_next    = EXC_INSTR_MISALIGNED;
            state_next  = EXC;
          end else begin
            req        = 1'b1;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (redirect_any) begin
          state_next = i_imem_rvalid ? FETCH : DRAIN;
        end else if (i_imem_rvalid) begin
          valid_next  = 1'b1;
          instr_next  = i_imem_err ? 32'd0 : i_imem_rdata;
          pc_out_next = pc;
          exc_next    = i_imem_err ? EXC_INSTR_ACCESS_FAULT : EXC_NONE;
          state_next  = PRESENT;
        end
      end
      DRAIN: begin
        if (i_imem_rvalid) state_next = FETCH;
      end
      PRESENT: begin
        if (redirect_any || !i_stall_f) begin
          if (!redirect_any) pc_sel = PC_INC;
          valid_next  = 1'b0;
          instr_next  = 32'd0;
          pc_out_next = 32'd0;
          exc_next    = EXC_NONE;
          state_next  = FETCH;
        end
      end
      EXC: begin
        if (redirect_any) begin
          valid_next  = 1'b0;
          instr_next  = 32'd0;
          pc_out_next = 32'd0;
          exc_next    = EXC_NONE;
          state_next  = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= IDLE;
      valid_reg  <= 1'b0;
      instr_reg  <= 32'd0;
      pc_out_reg <= 32'd0;
      exc_reg    <= EXC_NONE;
    end else if (i_clk_en) begin
      state_reg  <= state_next;
      valid_reg  <= valid_next;
      instr_reg  <= instr_next;
      pc_out_reg <= pc_out_next;
      exc_reg    <= exc_next;
    end
  end

  // Gating with the enable keeps the strobe to exactly one accepted cycle.
  assign o_imem_req         = req & i_clk_en;
  assign o_imem_addr        = pc;
  assign o_valid_f          = valid_reg;
  assign o_instr_f          = instr_reg;
  assign o_pc_f             = pc_out_reg;
  assign o_pc_p4_f          = valid_reg ? (pc_out_reg + 32'd4) : 32'd0;
  assign o_exception_code_f = exc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory responder and PC model predict each
// presented instruction/exception; a monitor compares what the stage presents.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clk_en = 1'b0;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] rpc = 32'd0;
  logic        trap = 1'b0;
  logic [31:0] tvec = 32'd0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic        err = 1'b0;
  logic        req;
  logic [31:0] addr;
  logic        valid;
  logic [31:0] instr, pcf, pcp4;
  logic [3:0]  exc;

  always #5 clk = ~clk;

  fetch_unit dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_clk_en           (clk_en),
    .i_stall_f          (stall),
    .i_redirect         (redir),
    .i_redirect_pc      (rpc),
    .i_trap             (trap),
    .i_trap_vector      (tvec),
    .o_imem_req         (req),
    .o_imem_addr        (addr),
    .i_imem_rvalid      (rvalid),
    .i_imem_rdata       (rdata),
    .i_imem_err         (err),
    .o_valid_f          (valid),
    .o_instr_f          (instr),
    .o_pc_f             (pcf),
    .o_pc_p4_f          (pcp4),
    .o_exception_code_f (exc)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  exc;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_pc = 32'd0;
  bit          pend = 0, pend_killed = 0, pend_err = 0, mis_exp = 0, rand_err = 0;
  logic [31:0] pend_addr = 32'd0;
  int          pend_wait = 0;
  int          lat_fix = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Drive one cycle's inputs (called just after a falling edge) and advance the model.
  task automatic step(input bit en, input bit st, input bit rd, input logic [31:0] rp,
                      input bit tr, input logic [31:0] tv, input bit stale);
    bit   deliver, consume;
    exp_t e;
    deliver = pend && en && (pend_wait == 0);
    clk_en = en; stall = st; redir = rd; rpc = rp; trap = tr; tvec = tv;
    rvalid = deliver || stale;
    rdata  = deliver ? (pend_err ? 32'hBAD0_BAD0 : mem_word(pend_addr)) : 32'h1234_5678;
    err    = deliver && pend_err;
    #1;
    if (en && valid) check("req_while_valid", req, 0);
    if (!en) check("req_when_disabled", req, 0);
    if (en && req) begin
      check("req_single_outstanding", pend, 0);
      check("req_addr", addr, exp_pc);
    end
    consume = en && valid && !st && !rd && !tr && !mis_exp;
    if (deliver) begin
      if (!pend_killed && !rd && !tr) begin
        e.instr = pend_err ? 32'd0 : mem_word(pend_addr);
        e.pc    = pend_addr;
        e.exc   = pend_err ? 4'h1 : 4'hF;
        exp_q.push_back(e);
      end
      pend = 0;
    end else if (pend && en) begin
      pend_wait--;
      if (rd || tr) pend_killed = 1;
    end
    if (en && req && !pend) begin
      pend        = 1;
      pend_killed = 0;
      pend_addr   = exp_pc;
      pend_wait   = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
      pend_err    = rand_err ? ($urandom_range(0, 5) == 0) : (exp_pc == 32'h8);
    end
    if (en) begin
      if (tr || rd) begin
        exp_pc  = tr ? tv : rp;
        mis_exp = (exp_pc[1:0] != 2'b00);
        if (mis_exp) begin
          e.instr = 32'd0; e.pc = exp_pc; e.exc = 4'h0;
          exp_q.push_back(e);
        end
      end else if (consume) begin
        exp_pc = exp_pc + 32'd4;
      end
    end
  endtask

  task automatic cyc(input bit st, input bit rd, input logic [31:0] rp,
                     input bit tr, input logic [31:0] tv);
    @(negedge clk);
    step(1'b1, st, rd, rp, tr, tv, 1'b0);
  endtask

  task automatic run_until_valid(input int max, input string nm);
    int i;
    for (i = 0; i < max; i++) begin
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      if (valid) break;
    end
    if (i == max) check(nm, 0, 1);
  endtask

  task automatic run_until_req(input int max, input string nm);
    int i;
    for (i = 0; i < max; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      if (req) break;
    end
    if (i == max) check(nm, 0, 1);
  endtask

  task automatic check_reset_outputs(input string nm);
    check(nm, {valid, instr, pcf, pcp4, exc, req}, {1'b0, 32'd0, 32'd0, 32'd0, 4'hF, 1'b0});
  endtask

  // Monitor: pops an expectation when a presentation starts, checks it every cycle it is held.
  exp_t cur;
  bit   have_cur = 0;
  bit   prev_v = 0;
  always @(negedge clk) begin
    #2;
    if (valid) begin
      if (!prev_v) begin
        if (exp_q.size() == 0) begin
          have_cur = 0;
          check("unexpected_valid_pc", pcf, 32'hFFFF_FFFF);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1;
          $display("[TB] present pc=%h instr=%h exc=%h", cur.pc, cur.instr, cur.exc);
        end
      end
      if (have_cur) begin
        check("instr", instr, cur.instr);
        check("pc", pcf, cur.pc);
        check("pc_p4", pcp4, cur.pc + 32'd4);
        check("exc", exc, cur.exc);
      end
    end else begin
      check("bubble", {instr, pcf, pcp4, exc}, {32'd0, 32'd0, 32'd0, 4'hF});
    end
    prev_v = valid;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    bit          en, st, rd, tr;
    logic [31:0] rp, tv;
    int          r;

    // Reset state, then plain fetch with 1-cycle memory.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_state");
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    repeat (3) cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    // Stall released; the killed word at 0x4 must never be presented.
    lat_fix = 2;
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 32'h100, 1'b0, 32'd0);
    lat_fix = 0;
    run_until_req(10, "timeout_req_100");
    run_until_valid(10, "timeout_valid_100");
    // Misaligned redirect, exception held regardless of stall, trap out.
    cyc(1'b1, 1'b1, 32'h102, 1'b0, 32'd0);
    run_until_valid(10, "timeout_misaligned");
    repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 32'h80);
    run_until_req(10, "timeout_req_80");
    run_until_valid(10, "timeout_valid_80");
    // Access fault at 0x8, held under stall until the trap.
    cyc(1'b1, 1'b1, 32'h8, 1'b0, 32'd0);
    run_until_req(10, "timeout_req_8");
    run_until_valid(10, "timeout_fault");
    repeat (3) cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    // Simultaneous trap and redirect: trap wins.
    lat_fix = 3;
    cyc(1'b1, 1'b1, 32'h200, 1'b1, 32'h80);
    run_until_req(10, "timeout_req_prio");
    // Asynchronous reset in the middle of an outstanding request.
    @(negedge clk);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset_mid_wait");
    exp_q.delete(); pend = 0; mis_exp = 0; exp_pc = RESET_PC_DEFAULT;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    lat_fix = 0;
    run_until_req(10, "timeout_req_after_reset");

    // Randomized traffic: enables, stalls, redirects, traps, faults, latencies.
    lat_fix = -1;
    rand_err = 1;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      en = ($urandom_range(0, 7) != 0);
      st = ($urandom_range(0, 2) == 0);
      rd = 0; tr = 0; rp = 32'd0; tv = 32'd0;
      a  = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      if (mis_exp) begin
        if (valid) begin tr = 1; tv = a; end
      end else begin
        r = int'($urandom_range(0, 19));
        case (r)
          0: begin tr = 1; tv = a; end
          1: begin rd = 1; rp = a; end
          2: begin rd = 1; rp = a | 32'($urandom_range(1, 3)); end
          3: begin tr = 1; tv = a; rd = 1; rp = a + 32'h40 + 32'($urandom_range(0, 3)); end
          default: ;
        endcase
      end
      step(en, st, rd, rp, tr, tv, 1'b0);
    end

    // Drain under stall so every predicted presentation has appeared.
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mis_exp && valid) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h40, 1'b0);
      else step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    end
    @(negedge clk);
    #3;
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
